// File: rtl/sprite_shift_scheduler.sv
// Sequences one sprite blit through the 4-quadrant mask shifter, then writes each
// non-empty, on-map quadrant to its tile in the tile mask buffer.
module sprite_shift_scheduler #(
    parameter int SHIFT_LATENCY = 2,
    parameter int TILES_X       = 40,
    parameter int TILES_Y       = 30,
    parameter int X_W           = 9,
    parameter int Y_W           = 8,
    parameter int ADDR_W        = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [X_W-1:0]    req_x,
    input  logic [Y_W-1:0]    req_y,
    input  logic [127:0]      req_mask,
    output logic              sh_clk_en,
    output logic [2:0]        sh_offset_x,
    output logic [2:0]        sh_offset_y,
    output logic [127:0]      sh_mask,
    input  logic [127:0]      sh_mask0,
    input  logic [127:0]      sh_mask1,
    input  logic [127:0]      sh_mask2,
    input  logic [127:0]      sh_mask3,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [127:0]      wr_mask,
    output logic [1:0]        wr_quad,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // once valid is raised, the payload stays stable until that transfer.

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CAPTURE, S_WRITE} state_t;

    localparam int TX_W  = X_W - 2;
    localparam int TY_W  = Y_W - 2;
    localparam int CNT_W = (SHIFT_LATENCY > 1) ? $clog2(SHIFT_LATENCY) : 1;

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [X_W-1:0]  x_q;
    logic [Y_W-1:0]  y_q;
    logic [127:0]    mask_q;
    logic [127:0]    q0_q, q1_q, q2_q, q3_q;
    logic [1:0]      quad_q;
    logic            req_ready_q, busy_q, done_q, sh_clk_en_q;

    logic [TX_W-1:0]   tx;
    logic [TY_W-1:0]   ty;
    logic [127:0]      cur_mask;
    logic              on_map;
    logic              need_wr;
    logic [ADDR_W-1:0] addr;

    // Tile coordinates carry one extra bit so the +1 spill never wraps back onto the map.
    always_comb begin
        tx       = TX_W'(x_q[X_W-1:3]) + TX_W'(quad_q[0]);
        ty       = TY_W'(y_q[Y_W-1:3]) + TY_W'(quad_q[1]);
        on_map   = (int'(tx) < TILES_X) && (int'(ty) < TILES_Y);
        addr     = ADDR_W'(ty) * ADDR_W'(TILES_X) + ADDR_W'(tx);
        cur_mask = q0_q;
        case (quad_q)
            2'd0: cur_mask = q0_q;
            2'd1: cur_mask = q1_q;
            2'd2: cur_mask = q2_q;
            2'd3: cur_mask = q3_q;
            default: cur_mask = q0_q;
        endcase
        need_wr  = on_map && (|cur_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            mask_q      <= '0;
            q0_q        <= '0;
            q1_q        <= '0;
            q2_q        <= '0;
            q3_q        <= '0;
            quad_q      <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sh_clk_en_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        x_q         <= req_x;
                        y_q         <= req_y;
                        mask_q      <= req_mask;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        sh_clk_en_q <= 1'b1;
                        state_q     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == CNT_W'(SHIFT_LATENCY - 1)) begin
                        sh_clk_en_q <= 1'b0;
                        state_q     <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    q0_q    <= sh_mask0;
                    q1_q    <= sh_mask1;
                    q2_q    <= sh_mask2;
                    q3_q    <= sh_mask3;
                    quad_q  <= 2'd0;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    // Skipped quadrants advance immediately; real writes wait for the handshake.
                    if (!need_wr || wr_ready) begin
                        if (quad_q == 2'd3) begin
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            req_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            quad_q <= quad_q + 2'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sh_clk_en   = sh_clk_en_q;
    assign sh_offset_x = x_q[2:0];
    assign sh_offset_y = y_q[2:0];
    assign sh_mask     = mask_q;
    assign wr_valid    = (state_q == S_WRITE) && need_wr;
    assign wr_addr     = wr_valid ? addr : '0;
    assign wr_mask     = wr_valid ? cur_mask : '0;
    assign wr_quad     = wr_valid ? quad_q : 2'd0;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sprite_shift_scheduler.sv
// Bench for sprite_shift_scheduler: a behavioural 2-stage shifter feeds the quadrant inputs,
// expected tile writes are queued per request and matched against every write handshake.
module tb_sprite_shift_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [8:0]   req_x = '0;
    logic [7:0]   req_y = '0;
    logic [127:0] req_mask = '0;
    logic         sh_clk_en;
    logic [2:0]   sh_offset_x, sh_offset_y;
    logic [127:0] sh_mask;
    logic [127:0] sh_mask0, sh_mask1, sh_mask2, sh_mask3;
    logic         wr_valid;
    logic         wr_ready = 1'b1;
    logic [10:0]  wr_addr;
    logic [127:0] wr_mask;
    logic [1:0]   wr_quad;
    logic         busy, done;
    logic [1:0]   dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [140:0] exp_q[$];
    int           act_addr_q[$];
    int           act_cyc_q[$];

    sprite_shift_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_mask(req_mask),
        .sh_clk_en(sh_clk_en), .sh_offset_x(sh_offset_x), .sh_offset_y(sh_offset_y),
        .sh_mask(sh_mask),
        .sh_mask0(sh_mask0), .sh_mask1(sh_mask1), .sh_mask2(sh_mask2), .sh_mask3(sh_mask3),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_mask(wr_mask),
        .wr_quad(wr_quad), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Quadrant q of the shifted mask; spill quadrants of a zero offset are empty.
    function automatic logic [127:0] shq(input logic [127:0] m, input int q,
                                         input logic [2:0] ox, input logic [2:0] oy);
        if (((q % 2) == 1 && ox == 3'd0) || (q >= 2 && oy == 3'd0)) return '0;
        return m ^ {16{8'(q * 37 + int'(ox) * 5 + int'(oy))}};
    endfunction

    logic [127:0] s1[4] = '{default: '0};
    logic [127:0] s2[4] = '{default: '0};
    always @(posedge clk) begin
        if (sh_clk_en) begin
            for (int q = 0; q < 4; q++) begin
                s1[q] <= shq(sh_mask, q, sh_offset_x, sh_offset_y);
                s2[q] <= s1[q];
            end
        end
    end
    assign sh_mask0 = s2[0];
    assign sh_mask1 = s2[1];
    assign sh_mask2 = s2[2];
    assign sh_mask3 = s2[3];

    // scoreboard: every write handshake pops one expected {quad, addr, mask}
    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready) begin
            logic [140:0] e;
            act_addr_q.push_back(int'(wr_addr));
            act_cyc_q.push_back(cyc);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL write_unexpected: got quad=%0d addr=%0d, expected no write", wr_quad, wr_addr);
            end else begin
                e = exp_q.pop_front();
                if ({wr_quad, wr_addr, wr_mask} !== e) begin
                    n_bad++;
                    $display("FAIL write_data: got quad=%0d addr=%0d mask=%h, expected quad=%0d addr=%0d mask=%h",
                             wr_quad, wr_addr, wr_mask, e[140:139], e[138:128], e[127:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic push_expected(input int x, input int y, input logic [127:0] m);
        for (int q = 0; q < 4; q++) begin
            int tx, ty;
            logic [127:0] qm;
            tx = x / 8 + (q % 2);
            ty = y / 8 + (q / 2);
            qm = shq(m, q, 3'(x % 8), 3'(y % 8));
            if (tx < 40 && ty < 30 && qm != '0)
                exp_q.push_back({2'(q), 11'(ty * 40 + tx), qm});
        end
    endtask

    // Presents a request and returns the accept cycle; leaves time just inside the next cycle.
    task automatic do_req(input int x, input int y, input logic [127:0] m, output int acc);
        bit ok = 0;
        act_addr_q.delete();
        act_cyc_q.delete();
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_x     = 9'(x);
        req_y     = 8'(y);
        req_mask  = m;
        acc       = -100;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                ok  = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL req_accept: req_ready=%0b after 50 cycles, expected 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, busy, done, wr_valid, sh_clk_en, dbg_state} !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset_ctrl: ready/busy/done/wr_valid/en/state=%b, expected 1000000",
                     {req_ready, busy, done, wr_valid, sh_clk_en, dbg_state});
        end
        n_cmp++;
        if ({sh_offset_x, sh_offset_y, sh_mask, wr_addr, wr_mask, wr_quad} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: offx=%0d offy=%0d addr=%0d, expected all zero",
                     sh_offset_x, sh_offset_y, wr_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int acc, dc;
        int exp_addr[4] = '{81, 82, 121, 122};
        wr_ready = 1'b1;
        push_expected(13, 21, '1);
        do_req(13, 21, '1, acc);
        @(negedge clk);
        n_cmp++;
        if ({sh_clk_en, sh_offset_x, sh_offset_y} !== 7'b1_101_101) begin
            n_bad++;
            $display("FAIL basic_shift_c1: en=%0b offx=%0d offy=%0d, expected en=1 offx=5 offy=5",
                     sh_clk_en, sh_offset_x, sh_offset_y);
        end
        @(negedge clk);
        n_cmp++;
        if (sh_clk_en !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_shift_c2: en=%0b, expected 1", sh_clk_en);
        end
        @(negedge clk);
        n_cmp++;
        if (sh_clk_en !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_capture_c3: en=%0b, expected 0", sh_clk_en);
        end
        wait_done(dc);
        n_cmp++;
        if (dc - acc !== 8) begin
            n_bad++;
            $display("FAIL basic_done_cycle: got %0d, expected 8", dc - acc);
        end
        for (int i = 0; i < 4; i++) begin
            int a, c;
            a = (i < act_addr_q.size()) ? act_addr_q[i] : -1;
            c = (i < act_cyc_q.size()) ? act_cyc_q[i] - acc : -1;
            n_cmp++;
            if (a !== exp_addr[i] || c !== 4 + i) begin
                n_bad++;
                $display("FAIL basic_write%0d: addr=%0d cycle=%0d, expected addr=%0d cycle=%0d",
                         i, a, c, exp_addr[i], 4 + i);
            end
        end
    endtask

    task automatic test_zero_offset;
        int acc, dc;
        logic [127:0] m;
        m = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        push_expected(16, 8, m);
        do_req(16, 8, m, acc);
        wait_done(dc);
        n_cmp++;
        if (dc - acc !== 8 || act_addr_q.size() !== 1) begin
            n_bad++;
            $display("FAIL zero_off_count: done=%0d writes=%0d, expected done=8 writes=1",
                     dc - acc, act_addr_q.size());
        end else begin
            n_cmp++;
            if (act_addr_q[0] !== 42 || act_cyc_q[0] - acc !== 4) begin
                n_bad++;
                $display("FAIL zero_off_write: addr=%0d cycle=%0d, expected addr=42 cycle=4",
                         act_addr_q[0], act_cyc_q[0] - acc);
            end
        end
        // an empty mask skips all four quadrants but still completes
        do_req(16, 8, '0, acc);
        wait_done(dc);
        n_cmp++;
        if (dc - acc !== 8 || act_addr_q.size() !== 0) begin
            n_bad++;
            $display("FAIL empty_mask: done=%0d writes=%0d, expected done=8 writes=0",
                     dc - acc, act_addr_q.size());
        end
    endtask

    task automatic test_corner;
        int acc, dc;
        push_expected(319, 239, '1);
        do_req(319, 239, '1, acc);
        wait_done(dc);
        n_cmp++;
        if (dc - acc !== 8 || act_addr_q.size() !== 1) begin
            n_bad++;
            $display("FAIL corner_count: done=%0d writes=%0d, expected done=8 writes=1",
                     dc - acc, act_addr_q.size());
        end else begin
            n_cmp++;
            if (act_addr_q[0] !== 1199) begin
                n_bad++;
                $display("FAIL corner_addr: got %0d, expected 1199", act_addr_q[0]);
            end
        end
    endtask

    task automatic test_stall;
        int acc, dc;
        logic [140:0] first;
        int exp_addr[4] = '{81, 82, 121, 122};
        wr_ready = 1'b1;
        push_expected(13, 21, '1);
        do_req(13, 21, '1, acc);
        repeat (4) @(posedge clk);
        #1;
        wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) first = {wr_quad, wr_addr, wr_mask};
            n_cmp++;
            if (wr_valid !== 1'b1 || wr_quad !== 2'd1 || wr_addr !== 11'd82 ||
                {wr_quad, wr_addr, wr_mask} !== first) begin
                n_bad++;
                $display("FAIL stall_hold%0d: valid=%0b quad=%0d addr=%0d, expected valid=1 quad=1 addr=82 stable",
                         k, wr_valid, wr_quad, wr_addr);
            end
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        wait_done(dc);
        n_cmp++;
        if (dc - acc !== 11) begin
            n_bad++;
            $display("FAIL stall_done_cycle: got %0d, expected 11", dc - acc);
        end
        for (int i = 0; i < 4; i++) begin
            int a;
            a = (i < act_addr_q.size()) ? act_addr_q[i] : -1;
            n_cmp++;
            if (a !== exp_addr[i]) begin
                n_bad++;
                $display("FAIL stall_write%0d: addr=%0d, expected %0d", i, a, exp_addr[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int acc, dc;
        bit hold_ok = 1;
        logic [127:0] ma, mb;
        ma = {$urandom, $urandom, $urandom, $urandom} | 128'h2;
        mb = {$urandom, $urandom, $urandom, $urandom};
        wr_ready = 1'b1;
        push_expected(16, 8, ma);
        do_req(16, 8, ma, acc);
        // keep requesting with a second sprite while the first is in flight
        req_valid = 1'b1;
        req_x     = 9'd13;
        req_y     = 8'd21;
        req_mask  = mb;
        push_expected(13, 21, mb);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (req_ready !== 1'b0 || busy !== 1'b1 || sh_offset_x !== 3'd0 || sh_mask !== ma)
                hold_ok = 0;
        end
        n_cmp++;
        if (!hold_ok) begin
            n_bad++;
            $display("FAIL busy_hold: ready/busy/offset/mask changed during busy, expected ready=0 busy=1 offx=0 first mask");
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || req_ready !== 1'b1 || cyc - acc !== 8) begin
            n_bad++;
            $display("FAIL b2b_first_done: done=%0b ready=%0b cycle=%0d, expected 1 1 8",
                     done, req_ready, cyc - acc);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done(dc);
        n_cmp++;
        if (dc - acc !== 16) begin
            n_bad++;
            $display("FAIL b2b_second_done: got %0d, expected 16", dc - acc);
        end
    endtask

    task automatic test_reset_mid;
        int acc;
        bit quiet = 1;
        wr_ready = 1'b0;
        do_req(13, 21, '1, acc);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (wr_valid !== 1'b1 || wr_quad !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_mid_pre: valid=%0b quad=%0d, expected valid=1 quad=0", wr_valid, wr_quad);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wr_valid, busy, req_ready, done} !== 4'b0010) begin
            n_bad++;
            $display("FAIL rst_mid_post: valid/busy/ready/done=%b, expected 0010",
                     {wr_valid, busy, req_ready, done});
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL rst_mid_quiet: done or busy rose after reset, expected both 0");
        end
        wr_ready = 1'b1;
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            int acc, x, y;
            bit seen = 0;
            logic [127:0] m;
            x = $urandom_range(0, 511);
            y = $urandom_range(0, 255);
            m = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
            push_expected(x, y, m);
            do_req(x, y, m, acc);
            for (int i = 0; i < 200; i++) begin
                @(posedge clk); #1;
                wr_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (done) begin
                    seen = 1;
                    break;
                end
            end
            wr_ready = 1'b1;
            n_cmp++;
            if (!seen || exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL random%0d: done_seen=%0b pending=%0d, expected 1 and 0",
                         r, seen, exp_q.size());
            end
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_offset;
        test_corner;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        test_random;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL final_queue: %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
